fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It sits beside the ID stage and keeps a registered shift-register scoreboard of the destination registers of the instructions in flight in EX, MEM, WB and any further stages, up to `DEPTH` slots. From that scoreboard it chooses, for each ALU operand and for the store data, the youngest stage holding a matching result. It also generates a stall when the youngest matching producer has not yet produced its value (load-use), inserting a bubble automatically.

## Interface
- `REG_AW`, default 5: register-address width.
- `DEPTH`, default 3: number of tracked in-flight slots; slot 0 = EX, 1 = MEM, 2 = WB, and so on. Legal range 2..7.
- `LOAD_RDY`, default 1: first slot index at which a load result is forwardable.
- `SEL_W`, default 3: select width; must satisfy 2^SEL_W >= DEPTH+2.
- `CNT_W`, default 16: stall-counter width.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset_L`  in  1  synchronous, active-low reset.
- `ID_Valid`  in  1  ID holds a real instruction.
- `Flush`  in  1  the ID instruction is squashed this cycle.
- `ID_Rs`, `ID_Rt`  in  REG_AW  source register addresses.
- `UsesRs`, `UsesRt`  in  1  operand is actually read. UsesRt is also set for stores.
- `UseShamt`, `UseImmed`  in  1  ALU A / B input comes from shamt / immediate.
- `ID_Rw`  in  REG_AW  destination register of the ID instruction.
- `ID_RegWrite`, `ID_MemRead`  in  1  the ID instruction writes a register / is a load.
- `AluSelA`, `AluSelB`  out  SEL_W  ALU operand selects. 0 = register file; k+1 = result of slot k; DEPTH+1 = shamt (A) or immediate (B).
- `StoreSel`  out  SEL_W  store-data select, same encoding; never DEPTH+1.
- `Stall`  out  1  hold PC and IF/ID; bubble enters EX.
- `StallCount`  out  CNT_W  saturating count of stall cycles.

## Operation
- Each slot holds {valid, rw, regwrite, load}.
- An entry is ready when `load==0`, or when its slot index is >= LOAD_RDY.
- Hit rule for a source address `s`:
  - Among slots with valid && regwrite && rw==s && rw!=0, take the lowest index k.
  - Older duplicates are ignored.
- Operand A:
  - UseShamt=1 gives DEPTH+1.
  - Otherwise, a ready hit gives k+1.
  - Otherwise 0. This includes an un-ready hit, which is reported via Stall instead.
- Operand B: same as A, using UseImmed and ID_Rt.
- StoreSel: the hit rule on ID_Rt, regardless of UseImmed. If there is no hit, the output is 0.
- A "blocking" operand is one that is read and whose youngest hit is not ready:
  - For A: UsesRs && !UseShamt && (hit on Rs not ready).
  - For B: UsesRt && (hit on Rt not ready).
- Stall = ID_Valid && !Flush && (blocking A || blocking B).
- Shift on every clock edge:
  - Slot k+1 takes slot k; the oldest slot's entry is discarded.
  - Slot 0 takes {ID_Valid && !Flush && !Stall, ID_Rw, ID_RegWrite, ID_MemRead}. A stall or flush therefore inserts a bubble.
- StallCount increments on each cycle with Stall=1 and saturates at all-ones.
- All outputs except StallCount are combinational from the scoreboard and the ID inputs. No output depends combinationally on itself.

## Timing
- Reset: on a rising edge with Reset_L=0, all slots are cleared to valid=0 and StallCount=0.
  - In the cycle after reset: Stall=0, StoreSel=0.
  - AluSelA/AluSelB = 0, or DEPTH+1 if UseShamt/UseImmed is set.
- Reset_L=0 mid-stall: Stall drops in the next cycle and the pending load entry is lost.
- Forwarding latency: a producer issued at edge t is visible in slot 0 from edge t.
  - A dependent instruction in ID during the following cycle sees select 1.
- Load-use latency:
  - With a load in slot 0 and a dependent read in ID, Stall=1 for exactly LOAD_RDY cycles.
  - The following cycle has select LOAD_RDY+1.
- Stall takes effect in the same cycle it asserts; ID inputs must be held stable by the pipeline while Stall=1.
- Flush and Stall in the same cycle: Flush wins, Stall=0, and a bubble enters slot 0.
- Register $0 never produces a hit.
- An instruction with ID_Rw==ID_Rs does not hit itself, since only slots are compared.

## Test plan
- ALU back-to-back:
  - Stimulus: add $3 (RegWrite=1), then a consumer with Rs=3, UsesRs=1.
  - Required: AluSelA=1, Stall=0. Two cycles later with no new writer, AluSelA=3 (WB). With DEPTH=3, the cycle after that gives 0.
- Youngest wins:
  - Stimulus: writers to $5 in slots 0 and 1; consumer with Rt=5, UseImmed=0.
  - Required: AluSelB=1, StoreSel=1.
- Load-use:
  - Stimulus: lw $7 issued, then a consumer with Rs=7.
  - Required: Stall=1 for one cycle and StallCount goes 0→1. The slot 0 bubble appears and the next cycle gives AluSelA=2, Stall=0.
- Immediate/shamt/$0:
  - Stimulus: UseImmed=1 and UseShamt=1 with hits present; a separately issued writer to $0.
  - Required: AluSelB=4, AluSelA=4 (DEPTH=3); the $0 write yields select 0.
- Flush vs. stall:
  - Stimulus: load in slot 0 and a dependent ID instruction with Flush=1.
  - Required: Stall=0, StallCount unchanged, and the bubble enters slot 0.
- Reset and saturation:
  - Stimulus: Reset_L=0 mid load-use stall; separately, CNT_W=4 with 20 stall cycles.
  - Required: the next cycle has Stall=0 and all selects 0; the counter holds at 15.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage hazard bus: instruction fields in, operand selects / stall out.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              ID_Valid;
  logic              Flush;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              UsesRs;
  logic              UsesRt;
  logic              UseShamt;
  logic              UseImmed;
  logic [REG_AW-1:0] ID_Rw;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic [SEL_W-1:0]  AluSelA;
  logic [SEL_W-1:0]  AluSelB;
  logic [SEL_W-1:0]  StoreSel;
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;

  // ID stage side: supplies the decoded instruction, consumes the selects
  modport master (
    output ID_Valid, Flush, ID_Rs, ID_Rt, UsesRs, UsesRt, UseShamt, UseImmed,
           ID_Rw, ID_RegWrite, ID_MemRead,
    input  AluSelA, AluSelB, StoreSel, Stall, StallCount
  );

  // Hazard unit side
  modport slave (
    input  ID_Valid, Flush, ID_Rs, ID_Rt, UsesRs, UsesRt, UseShamt, UseImmed,
           ID_Rw, ID_RegWrite, ID_MemRead,
    output AluSelA, AluSelB, StoreSel, Stall, StallCount
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit: shift-register scoreboard of in-flight
// destinations (slot 0 = EX), youngest-match operand selects and load-use stall.
module fwd_hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_RDY = 1,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned CNT_W    = 16
) (
  input logic                   CLK,
  input logic                   Reset_L,
  fwd_hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rw;
    logic              regwrite;
    logic              load;
  } slot_t;

  localparam logic [SEL_W-1:0] SEL_EXT = SEL_W'(DEPTH + 1);

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             hit_rs, rdy_rs, hit_rt, rdy_rt;
  logic [SEL_W-1:0] sel_rs, sel_rt;
  logic             blk_a, blk_b, stall;

  // Youngest matching producer for Rs and Rt; the first hit found while
  // scanning upward from slot 0 masks any older duplicates.
  always_comb begin
    hit_rs = 1'b0;
    rdy_rs = 1'b0;
    sel_rs = '0;
    hit_rt = 1'b0;
    rdy_rt = 1'b0;
    sel_rt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!hit_rs && slot_q[k].valid && slot_q[k].regwrite &&
          slot_q[k].rw == bus.ID_Rs && slot_q[k].rw != '0) begin
        hit_rs = 1'b1;
        sel_rs = SEL_W'(k + 1);
        rdy_rs = !slot_q[k].load || (k >= LOAD_RDY);
      end
      if (!hit_rt && slot_q[k].valid && slot_q[k].regwrite &&
          slot_q[k].rw == bus.ID_Rt && slot_q[k].rw != '0) begin
        hit_rt = 1'b1;
        sel_rt = SEL_W'(k + 1);
        rdy_rt = !slot_q[k].load || (k >= LOAD_RDY);
      end
    end
  end

  // Stall when a read operand's youngest producer is a load not yet forwardable
  always_comb begin
    blk_a = bus.UsesRs && !bus.UseShamt && hit_rs && !rdy_rs;
    blk_b = bus.UsesRt && hit_rt && !rdy_rt;
    stall = bus.ID_Valid && !bus.Flush && (blk_a || blk_b);
  end

  assign bus.AluSelA    = bus.UseShamt ? SEL_EXT : ((hit_rs && rdy_rs) ? sel_rs : '0);
  assign bus.AluSelB    = bus.UseImmed ? SEL_EXT : ((hit_rt && rdy_rt) ? sel_rt : '0);
  assign bus.StoreSel   = sel_rt;
  assign bus.Stall      = stall;
  assign bus.StallCount = cnt_q;

  // Next scoreboard contents: age every slot; stalled or flushed ID enters as a bubble
  always_comb begin
    slot_d[0].valid    = bus.ID_Valid && !bus.Flush && !stall;
    slot_d[0].rw       = bus.ID_Rw;
    slot_d[0].regwrite = bus.ID_RegWrite;
    slot_d[0].load     = bus.ID_MemRead;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
    cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Scoreboard and saturating stall counter registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Randomized + directed bench with a queue-based pipeline reference model and
// a decoupled scoreboard monitor. A second instance with CNT_W=4 checks saturation.
module tb_fwd_hazard_scoreboard;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_RDY = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(3), .CNT_W(16)) bus ();
  fwd_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(3), .CNT_W(4))  bus4 ();

  assign bus4.ID_Valid    = bus.ID_Valid;
  assign bus4.Flush       = bus.Flush;
  assign bus4.ID_Rs       = bus.ID_Rs;
  assign bus4.ID_Rt       = bus.ID_Rt;
  assign bus4.UsesRs      = bus.UsesRs;
  assign bus4.UsesRt      = bus.UsesRt;
  assign bus4.UseShamt    = bus.UseShamt;
  assign bus4.UseImmed    = bus.UseImmed;
  assign bus4.ID_Rw       = bus.ID_Rw;
  assign bus4.ID_RegWrite = bus.ID_RegWrite;
  assign bus4.ID_MemRead  = bus.ID_MemRead;

  fwd_hazard_scoreboard #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SEL_W(3), .CNT_W(16))
    dut (.CLK(clk), .Reset_L(rst_n), .bus(bus));
  fwd_hazard_scoreboard #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SEL_W(3), .CNT_W(4))
    dut4 (.CLK(clk), .Reset_L(rst_n), .bus(bus4));

  typedef struct {
    bit       rst_n, valid, flush, urs, urt, ush, uimm, we, ld;
    bit [4:0] rs, rt, rw;
  } stim_t;

  typedef struct packed {
    bit       v;
    bit [4:0] rw;
    bit       we;
    bit       ld;
  } ent_t;

  typedef struct {
    int sela, selb, ssel, stall, cnt16, cnt4;
  } exp_t;

  ent_t  pipe[$];
  exp_t  exp_q[$];
  int    cnt;
  bit    known;
  bit    last_stall;
  stim_t last_s;
  int    vectors;
  int    miscompares;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1'b1;
    s.valid = 1'b1;
    return s;
  endfunction

  // Youngest in-flight writer of register s (index into the age-ordered queue)
  function automatic void lookup(input bit [4:0] s, output bit hit, output int k, output bit rdy);
    hit = 0; k = 0; rdy = 0;
    if (s != 0) begin
      for (int i = 0; i < pipe.size(); i++) begin
        if (!hit && pipe[i].v && pipe[i].we && pipe[i].rw == s) begin
          hit = 1; k = i; rdy = !pipe[i].ld || (i >= int'(LOAD_RDY));
        end
      end
    end
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    bit ha, ra, hb, rb;
    int ka, kb;
    lookup(s.rs, ha, ka, ra);
    lookup(s.rt, hb, kb, rb);
    e.sela  = s.ush  ? DEPTH + 1 : ((ha && ra) ? ka + 1 : 0);
    e.selb  = s.uimm ? DEPTH + 1 : ((hb && rb) ? kb + 1 : 0);
    e.ssel  = hb ? kb + 1 : 0;
    e.stall = (s.valid && !s.flush &&
               ((s.urs && !s.ush && ha && !ra) || (s.urt && hb && !rb))) ? 1 : 0;
    e.cnt16 = (cnt > 65535) ? 65535 : cnt;
    e.cnt4  = (cnt > 15) ? 15 : cnt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of ID inputs, queue its expected response, advance the model
  task automatic step(input stim_t s);
    exp_t e;
    rst_n           = s.rst_n;
    bus.ID_Valid    = s.valid;
    bus.Flush       = s.flush;
    bus.ID_Rs       = s.rs;
    bus.ID_Rt       = s.rt;
    bus.UsesRs      = s.urs;
    bus.UsesRt      = s.urt;
    bus.UseShamt    = s.ush;
    bus.UseImmed    = s.uimm;
    bus.ID_Rw       = s.rw;
    bus.ID_RegWrite = s.we;
    bus.ID_MemRead  = s.ld;
    e = predict(s);
    if (known) exp_q.push_back(e);
    last_stall = known && (e.stall != 0);
    last_s     = s;
    @(posedge clk);
    if (!s.rst_n) begin
      pipe.delete();
      for (int i = 0; i < int'(DEPTH); i++) pipe.push_back('0);
      cnt   = 0;
      known = 1;
    end else if (known) begin
      if (e.stall != 0) cnt++;
      pipe.push_front('{v: s.valid && !s.flush && (e.stall == 0), rw: s.rw, we: s.we, ld: s.ld});
      void'(pipe.pop_back());
    end
    #1;
  endtask

  // Scoreboard monitor: compare each queued expectation mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("AluSelA",     32'(bus.AluSelA),     e.sela);
        chk("AluSelB",     32'(bus.AluSelB),     e.selb);
        chk("StoreSel",    32'(bus.StoreSel),    e.ssel);
        chk("Stall",       32'(bus.Stall),       e.stall);
        chk("StallCount",  32'(bus.StallCount),  e.cnt16);
        chk("StallCount4", 32'(bus4.StallCount), e.cnt4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s, c, lw;
    vectors = 0; miscompares = 0; cnt = 0; known = 0; last_stall = 0;
    last_s = idle();
    @(posedge clk); #1;

    s = idle(); s.rst_n = 0;
    step(s); step(s);
    s = idle(); s.urs = 1; s.urt = 1; s.rs = 3; s.rt = 4;
    step(s);                                   // post-reset: no hits, no stall
    s.ush = 1; s.uimm = 1; step(s);            // ext selects right after reset

    // ALU back-to-back then aging through MEM, WB and out
    s = idle(); s.rw = 3; s.we = 1; step(s);
    c = idle(); c.rs = 3; c.urs = 1;
    step(c); step(c); step(c); step(c);

    // Youngest of two writers wins on Rt / store data
    s = idle(); s.rw = 5; s.we = 1; step(s); step(s);
    c = idle(); c.rt = 5; c.urt = 1; step(c);

    // Load-use: one stall, then forward from MEM
    lw = idle(); lw.rw = 7; lw.we = 1; lw.ld = 1; step(lw);
    c = idle(); c.rs = 7; c.urs = 1; step(c); step(c);

    // Immediate/shamt override present hits; writer to $0 never hits
    s = idle(); s.rw = 6; s.we = 1; step(s);
    c = idle(); c.rs = 6; c.rt = 6; c.urs = 1; c.urt = 1; c.ush = 1; c.uimm = 1; step(c);
    s = idle(); s.rw = 0; s.we = 1; step(s);
    c = idle(); c.rs = 0; c.rt = 0; c.urs = 1; c.urt = 1; step(c);

    // Flush beats stall, bubble enters slot 0
    step(lw);
    c = idle(); c.rs = 7; c.urs = 1; c.flush = 1; step(c);
    c.flush = 0; step(c);

    // Reset while stalled drops the pending load
    step(lw);
    c = idle(); c.rs = 7; c.urs = 1; step(c);
    c.rst_n = 0; step(c);
    c.rst_n = 1; step(c);

    // Twenty stall cycles to drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      step(lw);
      c = idle(); c.rt = 7; c.urt = 1; step(c);
    end

    // Randomized traffic; the pipeline usually holds ID steady while stalled
    for (int i = 0; i < 1500; i++) begin
      if (last_stall && $urandom_range(0, 3) != 0) begin
        s = last_s;
        s.rst_n = 1;
      end else begin
        s = idle();
        s.valid = ($urandom_range(0, 9) != 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.rs    = 5'($urandom_range(0, 7));
        s.rt    = 5'($urandom_range(0, 7));
        s.rw    = 5'($urandom_range(0, 7));
        s.urs   = ($urandom_range(0, 3) != 0);
        s.urt   = ($urandom_range(0, 2) != 0);
        s.ush   = ($urandom_range(0, 7) == 0);
        s.uimm  = ($urandom_range(0, 3) == 0);
        s.we    = ($urandom_range(0, 3) != 0);
        s.ld    = ($urandom_range(0, 2) == 0);
        s.rst_n = ($urandom_range(0, 99) != 0);
      end
      step(s);
    end

    s = idle(); s.valid = 0;
    step(s);
    @(posedge clk); @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
